// File: rtl/darkio_dev_if.sv
// device_bus handshake bundle between the core (master) and a device port (slave).
interface darkio_dev_if;
  logic        EN;
  logic        RE;
  logic        WE;
  logic [31:0] ADDR;
  logic [3:0]  BE;
  logic [31:0] DATAI;
  logic [31:0] DATAO;
  logic        RACK;
  logic        WACK;

  modport master (output EN, RE, WE, ADDR, BE, DATAI, input DATAO, RACK, WACK);
  modport slave  (input EN, RE, WE, ADDR, BE, DATAI, output DATAO, RACK, WACK);
endinterface

// File: rtl/darkio_dev.sv
// Board I/O register block on device_bus: board info, IRQ status/ack, LED/GPIO latches
// and a reloading timer that raises IRQ7.
module darkio_dev #(
  parameter logic [7:0]  BOARD_ID = 8'd0,
  parameter int unsigned BOARD_CK = 100000000
) (
  input  logic        XCLK,
  input  logic        XRES,
  darkio_dev_if.slave bus,
  output logic [3:0]  LED,
  output logic [7:0]  IRQ
);
  localparam logic [7:0]  MHZ_F      = 8'(BOARD_CK / 1000000);
  localparam logic [7:0]  KHZ_F      = 8'((BOARD_CK / 10000) % 100);
  localparam logic [31:0] RELOAD_RST = 32'(BOARD_CK / 1000000 - 1);

  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t state, state_nx;

  logic        take;
  logic        wr_q;
  logic [31:0] dout;
  logic [15:0] led_q, gpio_q;
  logic [7:0]  ireq, iack, iack_w;
  logic [31:0] timer, reload;
  logic [31:0] rd_data;
  logic [1:0]  word;
  logic        addr_unused;

  assign word        = bus.ADDR[3:2];
  assign addr_unused = ^{bus.ADDR[31:4], bus.ADDR[1:0]};
  assign IRQ         = ireq ^ iack;
  assign LED         = led_q[3:0];
  assign bus.DATAO   = dout;
  // Ack is suppressed while reset is asserted so an aborted transaction never acks.
  assign bus.RACK    = (state == S_ACK) && !wr_q && !XRES;
  assign bus.WACK    = (state == S_ACK) &&  wr_q && !XRES;

  always_ff @(posedge XCLK) begin
    if (XRES) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      S_IDLE: if (bus.EN && (bus.RE || bus.WE)) begin
        state_nx = S_ACK;
        take     = 1'b1;
      end
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (word)
      2'd0: rd_data = {IRQ, KHZ_F, MHZ_F, BOARD_ID};
      2'd1: rd_data = '0;
      2'd2: rd_data = {gpio_q, led_q};
      2'd3: rd_data = reload;
      default: rd_data = '0;
    endcase
  end

  // Acknowledging copies the current request bit, so a request raised on this same edge stays pending.
  always_comb begin
    iack_w = iack;
    for (int unsigned i = 0; i < 8; i++)
      if (bus.DATAI[24+i]) iack_w[i] = ireq[i];
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      wr_q   <= 1'b0;
      dout   <= '0;
      led_q  <= '0;
      gpio_q <= '0;
      iack   <= '0;
      reload <= RELOAD_RST;
    end else if (take) begin
      wr_q <= bus.WE;
      if (bus.WE) begin
        dout <= '0;
        case (word)
          2'd0: if (bus.BE[3]) iack <= iack_w;
          2'd2: begin
            if (|bus.BE[1:0]) led_q  <= bus.DATAI[15:0];
            if (|bus.BE[3:2]) gpio_q <= bus.DATAI[31:16];
          end
          2'd3: if (bus.BE == 4'hF) reload <= bus.DATAI;
          default: ;
        endcase
      end else begin
        dout <= rd_data;
      end
    end
  end

  // A new RELOAD value only takes effect at the next wrap; the running count is untouched.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      timer <= '0;
      ireq  <= '0;
    end else if (reload != '0) begin
      if (timer == '0) begin
        timer <= reload;
        if (ireq == iack) ireq[7] <= ~iack[7];
      end else begin
        timer <= timer - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_darkio_dev.sv
// Self-checking bench for darkio_dev: directed literal checks plus a randomized run
// compared every cycle against a transaction-level model of the register block.
module tb_darkio_dev;
  localparam logic [7:0]  BID = 8'h05;
  localparam int unsigned BCK = 100000000;

  logic       XCLK = 1'b0;
  logic       XRES;
  logic [3:0] LED;
  logic [7:0] IRQ;

  darkio_dev_if bus();

  darkio_dev #(.BOARD_ID(BID), .BOARD_CK(BCK)) dut (
    .XCLK(XCLK), .XRES(XRES), .bus(bus), .LED(LED), .IRQ(IRQ)
  );

  always #5 XCLK = ~XCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 0;
  int          m_ph;           // 0 none, 1 read ack due, 2 write ack due
  logic [31:0] m_dout, m_timer, m_reload;
  logic [15:0] m_led, m_gpio;
  logic [7:0]  m_ireq, m_iack;

  always @(posedge XCLK) begin
    logic [7:0]  o_ireq, o_iack;
    logic [31:0] o_timer, o_reload;
    logic [15:0] o_led, o_gpio;
    int w;
    if (XRES) begin
      m_valid = 1; m_ph = 0; m_dout = 0; m_led = 0; m_gpio = 0;
      m_ireq = 0; m_iack = 0; m_timer = 0; m_reload = BCK / 1000000 - 1;
    end else if (m_valid) begin
      o_ireq = m_ireq; o_iack = m_iack; o_timer = m_timer; o_reload = m_reload;
      o_led = m_led; o_gpio = m_gpio;
      if (m_ph != 0) m_ph = 0;
      else if (bus.EN && (bus.RE || bus.WE)) begin
        w = int'(bus.ADDR[3:2]);
        if (bus.WE) begin
          m_ph = 2; m_dout = 0;
          if (w == 0 && bus.BE[3]) begin
            for (int i = 0; i < 8; i++) if (bus.DATAI[24+i]) m_iack[i] = o_ireq[i];
          end
          if (w == 2) begin
            if (bus.BE[1:0] != 0) m_led  = bus.DATAI[15:0];
            if (bus.BE[3:2] != 0) m_gpio = bus.DATAI[31:16];
          end
          if (w == 3 && bus.BE == 4'hF) m_reload = bus.DATAI;
        end else begin
          m_ph = 1;
          case (w)
            0: m_dout = {o_ireq ^ o_iack, 8'((BCK / 10000) % 100), 8'(BCK / 1000000), BID};
            2: m_dout = {o_gpio, o_led};
            3: m_dout = o_reload;
            default: m_dout = 0;
          endcase
        end
      end
      if (o_reload != 0) begin
        if (o_timer == 0) begin
          m_timer = o_reload;
          if (o_ireq == o_iack) m_ireq[7] = ~o_iack[7];
        end else m_timer = o_timer - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge XCLK) begin
    if (m_valid) begin
      chk("rack", 32'(bus.RACK), 32'(m_ph == 1 && !XRES));
      chk("wack", 32'(bus.WACK), 32'(m_ph == 2 && !XRES));
      chk("led",  32'(LED), 32'(m_led[3:0]));
      chk("irq",  32'(IRQ), 32'(m_ireq ^ m_iack));
      if (bus.RACK) chk("datao", bus.DATAO, m_dout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge XCLK); #1;
  endtask

  task automatic idle();
    bus.EN = 0; bus.RE = 0; bus.WE = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.EN = 1; bus.WE = 1; bus.RE = 0; bus.ADDR = a; bus.DATAI = d; bus.BE = be;
    tick();
    chk("wr_wack", 32'(bus.WACK), 32'd1);
    idle();
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.EN = 1; bus.RE = 1; bus.WE = 0; bus.ADDR = a; bus.BE = 4'h0;
    tick();
    chk("rd_rack", 32'(bus.RACK), 32'd1);
    d = bus.DATAO;
    idle();
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  pat;
    bit seen;
    XRES = 1; idle(); bus.ADDR = 0; bus.BE = 0; bus.DATAI = 0;
    tick(); tick(); tick();
    chk("rst_rack", 32'(bus.RACK), 0);
    chk("rst_wack", 32'(bus.WACK), 0);
    chk("rst_datao", bus.DATAO, 0);
    chk("rst_irq", 32'(IRQ), 0);
    chk("rst_led", 32'(LED), 0);

    // Read word 0 on the very first edge out of reset, before the timer's first wrap.
    XRES = 0; bus.EN = 1; bus.RE = 1; bus.ADDR = 32'h0;
    tick();
    chk("id_rack", 32'(bus.RACK), 1);
    chk("id_wack", 32'(bus.WACK), 0);
    chk("id_datao", bus.DATAO, 32'h00006405);
    idle(); tick();

    bus_write(32'h8, 32'hABCD1234, 4'b0011);
    chk("led_4", 32'(LED), 32'h4);
    bus_read(32'h8, rd);
    chk("ledgpio_rd", rd, 32'h00001234);

    bus.EN = 1; bus.RE = 1; bus.ADDR = 32'h8;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[i] = bus.RACK;
    end
    chk("rack_pattern", 32'(pat), 32'b010101);
    idle(); tick();

    bus_write(32'hC, 32'd3, 4'hF);
    bus_write(32'h0, 32'h80000000, 4'b1000);
    chk("irq_acked", 32'(IRQ), 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (IRQ == 8'h80) seen = 1;
    end
    chk("irq_raise", 32'(seen), 1);
    bus_write(32'h0, 32'h80000000, 4'b1000);
    chk("irq_ack2", 32'(IRQ), 0);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (IRQ == 8'h80) seen = 1;
      else tick();
    end
    chk("irq_rewrap", 32'(seen), 1);
    bus_read(32'hC, rd);
    chk("reload_rd", rd, 32'd3);

    bus.EN = 1; bus.RE = 1; bus.WE = 1; bus.ADDR = 32'h8; bus.DATAI = 32'h0000000F; bus.BE = 4'hF;
    tick();
    chk("rw_wack", 32'(bus.WACK), 1);
    chk("rw_rack", 32'(bus.RACK), 0);
    chk("rw_datao", bus.DATAO, 0);
    idle(); tick();
    chk("rw_led", 32'(LED), 32'hF);

    bus.EN = 1; bus.WE = 1; bus.ADDR = 32'hC; bus.DATAI = 32'd7; bus.BE = 4'hF;
    tick();
    XRES = 1; #1;
    chk("abort_wack", 32'(bus.WACK), 0);
    idle(); tick(); tick();
    chk("abort_led", 32'(LED), 0);
    chk("abort_irq", 32'(IRQ), 0);
    XRES = 0;
    bus_read(32'hC, rd);
    chk("abort_reload", rd, 32'd99);

    for (int c = 0; c < 1500; c++) begin
      XRES = ($urandom_range(0, 199) == 0);
      bus.EN = ($urandom_range(0, 3) != 0);
      bus.RE = $urandom_range(0, 1);
      bus.WE = ($urandom_range(0, 2) == 0);
      bus.ADDR = $urandom;
      bus.BE = 4'($urandom);
      bus.DATAI = (bus.ADDR[3:2] == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      if (bus.ADDR[3:2] == 2'd3 && $urandom_range(0, 1) == 0) bus.BE = 4'hF;
      tick();
    end
    XRES = 0; idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
